// File: rtl/imem_burst_loader_if.sv
// ---------------------------------------------------------------------------
// imem_burst_loader_if
//   Bus bundle between the program-image loader and the rest of the SoC.
//   It carries two independent buses:
//     - avm_rx_* : Avalon-MM burst-read master port toward SDRAM.
//     - imem_*   : write port into the rv32i instruction memory.
//
//   Parameters:
//     ADDR_WIDTH : imem word-address width.
//
//   Modports:
//     master : the loader (drives read command and imem writes).
//     slave  : SDRAM-side responder plus imem sink (drives stall/data).
//
//   Avalon handshake: a read command is transferred on the cycle where
//   avm_rx_read=1 and avm_rx_waitrequest=0; address and burstcount are held
//   stable while waitrequest=1. Each cycle with avm_rx_readdatavalid=1
//   delivers one beat on avm_rx_readdata.
// ---------------------------------------------------------------------------
interface imem_burst_loader_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  avm_rx_waitrequest;
  logic [11:0]           avm_rx_burstcount;
  logic [31:0]           avm_rx_address;
  logic                  avm_rx_read;
  logic [31:0]           avm_rx_readdata;
  logic                  avm_rx_readdatavalid;
  logic                  imem_wr;
  logic [ADDR_WIDTH-1:0] imem_waddr;
  logic [31:0]           imem_wdata;

  modport master (
    input  avm_rx_waitrequest,
    input  avm_rx_readdata,
    input  avm_rx_readdatavalid,
    output avm_rx_burstcount,
    output avm_rx_address,
    output avm_rx_read,
    output imem_wr,
    output imem_waddr,
    output imem_wdata
  );

  modport slave (
    output avm_rx_waitrequest,
    output avm_rx_readdata,
    output avm_rx_readdatavalid,
    input  avm_rx_burstcount,
    input  avm_rx_address,
    input  avm_rx_read,
    input  imem_wr,
    input  imem_waddr,
    input  imem_wdata
  );
endinterface

// File: rtl/imem_burst_loader.sv
// ---------------------------------------------------------------------------
// imem_burst_loader
//   Copies a RISC-V program image from SDRAM into instruction memory using
//   Avalon-MM burst reads, then releases the softcore from reset.
//
//   Parameters:
//     ADDR_WIDTH     : imem word-address width (capacity 2^ADDR_WIDTH words).
//     MAX_BURST      : maximum beats per burst (1..2047).
//     TIMEOUT_CYCLES : idle-beat watchdog limit (only with the macro below).
//
//   Optional feature macro: LOADER_TIMEOUT_EN
//     Defined     : a watchdog aborts a burst that stalls for TIMEOUT_CYCLES
//                   DATA cycles without a beat; error=1, done=1, core stays
//                   in reset.
//     Not defined : no watchdog logic, error is tied to 0.
//
//   Ports:
//     clk        : system clock.
//     reset      : asynchronous active-high reset.
//     start      : single-cycle load request (ignored while busy).
//     src_addr   : SDRAM byte address of the image, bits [1:0] ignored.
//     num_words  : words to copy (clamped to imem capacity).
//     busy       : load in progress.
//     done       : sticky completion flag, cleared by the next start.
//     error      : sticky abort flag, cleared by the next start.
//     core_rstn  : active-low reset to the rv32i core.
//     fsm_state  : current FSM state (0 IDLE, 1 REQ, 2 DATA, 3 FIN).
//     bus        : avm_rx master and imem write port (master modport).
// ---------------------------------------------------------------------------
module imem_burst_loader #(
  parameter int ADDR_WIDTH     = 12,
  parameter int MAX_BURST      = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           src_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  core_rstn,
  output logic [1:0]            fsm_state,
  imem_burst_loader_if.master   bus
);

  localparam int RW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t state;
  state_t state_n;

  // Load bookkeeping
  logic [31:0]           rd_addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [11:0]           beats_left;

  // Registered imem write port
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [31:0]           wdata_q;

  // Status
  logic done_q;
  logic rstn_q;
  logic release_pend;

  // Decoded events
  logic [ADDR_WIDTH:0] clamped_words;
  logic [11:0]         burst_len;
  logic                start_ok;
  logic                cmd_accept;
  logic                beat;
  logic                last_beat;
  logic                abort;
  logic                aborted;

  // The word-aligned address drops the two low bits of src_addr.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^src_addr[1:0];

  always_comb begin
    if (num_words > CAPACITY) clamped_words = CAPACITY;
    else                      clamped_words = num_words;
  end

  // Burst length is a pure function of registered state, so it stays
  // stable for as long as the slave holds waitrequest.
  always_comb begin
    if (32'(remaining) > 32'(MAX_BURST)) burst_len = 12'(MAX_BURST);
    else                                 burst_len = 12'(remaining);
  end

  assign start_ok  = (state == S_IDLE) && start;
  assign beat      = (state == S_DATA) && bus.avm_rx_readdatavalid;
  assign last_beat = beat && (beats_left == 12'd1);

`ifdef LOADER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            aborted_q;

  // Counter is zero outside DATA, so entering DATA always starts fresh.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt    <= '0;
      aborted_q <= 1'b0;
    end else begin
      if (state != S_DATA || bus.avm_rx_readdatavalid) wd_cnt <= '0;
      else                                             wd_cnt <= wd_cnt + WD_W'(1);

      if (start_ok)   aborted_q <= 1'b0;
      else if (abort) aborted_q <= 1'b1;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive beat-less DATA cycle.
  assign abort   = (state == S_DATA) && !bus.avm_rx_readdatavalid &&
                   (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign aborted = aborted_q;
  assign error   = done_q & aborted_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign abort   = 1'b0;
  assign aborted = 1'b0;
  assign error   = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // -------------------------------------------------------------------------
  // FSM next state and bus outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_n               = state;
    cmd_accept            = 1'b0;
    bus.avm_rx_read       = 1'b0;
    bus.avm_rx_address    = rd_addr;
    bus.avm_rx_burstcount = burst_len;
    busy                  = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (clamped_words == '0) state_n = S_FIN;
          else                     state_n = S_REQ;
        end
      end
      S_REQ: begin
        busy            = 1'b1;
        bus.avm_rx_read = 1'b1;
        if (!bus.avm_rx_waitrequest) begin
          cmd_accept = 1'b1;
          state_n    = S_DATA;
        end
      end
      S_DATA: begin
        busy = 1'b1;
        // Only one burst is ever outstanding; the next command waits for
        // the final beat of the current one.
        if (last_beat) begin
          if (remaining != '0) state_n = S_REQ;
          else                 state_n = S_FIN;
        end else if (abort) begin
          state_n = S_FIN;
        end
      end
      S_FIN: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath and status registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr      <= '0;
      remaining    <= '0;
      wr_ptr       <= '0;
      beats_left   <= '0;
      wr_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      done_q       <= 1'b0;
      rstn_q       <= 1'b0;
      release_pend <= 1'b0;
    end else begin
      wr_q         <= 1'b0;
      release_pend <= 1'b0;

      if (start_ok) begin
        rd_addr   <= {src_addr[31:2], 2'b00};
        remaining <= clamped_words;
        wr_ptr    <= '0;
        done_q    <= 1'b0;
        rstn_q    <= 1'b0;
      end

      if (cmd_accept) begin
        beats_left <= burst_len;
        remaining  <= remaining - RW'(burst_len);
        rd_addr    <= rd_addr + {18'd0, burst_len, 2'b00};
      end

      if (beat) begin
        wr_q       <= 1'b1;
        waddr_q    <= wr_ptr;
        wdata_q    <= bus.avm_rx_readdata;
        wr_ptr     <= wr_ptr + ADDR_WIDTH'(1);
        beats_left <= beats_left - 12'd1;
      end

      // done rises the cycle after FIN; core_rstn one cycle after that,
      // so the last imem write has landed before the core leaves reset.
      if (state == S_FIN) begin
        done_q       <= 1'b1;
        release_pend <= !aborted;
      end

      if (release_pend) rstn_q <= 1'b1;
    end
  end

  assign bus.imem_wr    = wr_q;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign done           = done_q;
  assign core_rstn      = rstn_q;
  assign fsm_state      = state;

endmodule

// File: tb/tb_imem_burst_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_burst_loader
//   Directed bench for imem_burst_loader. An SDRAM responder returns each
//   word's own byte address as data, so image word k from base B is B+4*k.
//   Expected bursts are queued as {burstcount, address} before each load.
// ---------------------------------------------------------------------------
module tb_imem_burst_loader;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   src_addr;
  logic [AW:0]   num_words;
  logic          busy;
  logic          done;
  logic          error;
  logic          core_rstn;
  logic [1:0]    fsm_state;

  imem_burst_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_burst_loader #(
    .ADDR_WIDTH    (AW),
    .MAX_BURST     (256),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .src_addr (src_addr),
    .num_words(num_words),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .core_rstn(core_rstn),
    .fsm_state(fsm_state),
    .bus      (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          n_total = 0;
  int          n_pass  = 0;
  logic [43:0] exp_q[$];          // {burstcount, address}
  logic [31:0] img_base = '0;
  int          wr_count = 0;
  int          bad_wr   = 0;
  int          n_reads  = 0;
  int          last_valid_cyc = 0;
  int          last_wr_cyc    = 0;
  bit          stall_mode  = 1'b0;
  bit          gap_mode    = 1'b0;
  bit          junk_valid  = 1'b0;
  int          beat_budget = -1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- SDRAM responder ----------------
  task automatic slave_proc();
    int          beats_pend = 0;
    logic [31:0] beat_addr  = '0;
    int          stall_left = 0;
    bit          in_cmd     = 1'b0;
    bit          acc;
    logic [31:0] a;
    logic [11:0] bc;
    forever begin
      @(negedge clk);
      acc = bus.avm_rx_read && !bus.avm_rx_waitrequest && !reset;
      a   = bus.avm_rx_address;
      bc  = bus.avm_rx_burstcount;
      @(posedge clk);
      #1;
      if (reset) begin
        beats_pend = 0;
        in_cmd     = 1'b0;
        bus.avm_rx_waitrequest   = 1'b0;
        bus.avm_rx_readdatavalid = 1'b0;
        bus.avm_rx_readdata      = '0;
        continue;
      end
      if (acc) begin
        check("burst_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("burst_cmd", {bc, a}, exp_q.pop_front());
        beats_pend = int'(bc);
        beat_addr  = a;
      end
      if (junk_valid) begin
        bus.avm_rx_readdatavalid = 1'b1;
        bus.avm_rx_readdata      = 32'hdead_beef;
      end else if (beats_pend > 0 && beat_budget != 0 &&
                   (!gap_mode || $urandom_range(0, 2) != 0)) begin
        bus.avm_rx_readdatavalid = 1'b1;
        bus.avm_rx_readdata      = beat_addr;
        beat_addr  = beat_addr + 32'd4;
        beats_pend = beats_pend - 1;
        if (beat_budget > 0) beat_budget = beat_budget - 1;
      end else begin
        bus.avm_rx_readdatavalid = 1'b0;
        bus.avm_rx_readdata      = '0;
      end
      if (bus.avm_rx_read) begin
        if (!in_cmd) begin
          in_cmd     = 1'b1;
          stall_left = stall_mode ? int'($urandom_range(3, 5)) : 0;
        end
        bus.avm_rx_waitrequest = (stall_left > 0);
        if (stall_left > 0) stall_left = stall_left - 1;
      end else begin
        in_cmd = 1'b0;
        bus.avm_rx_waitrequest = 1'b0;
      end
    end
  endtask

  // ---------------- imem / command monitor ----------------
  task automatic monitor_proc();
    bit          prev_stalled = 1'b0;
    logic [31:0] prev_addr    = '0;
    logic [11:0] prev_bc      = '0;
    forever begin
      @(negedge clk);
      if (bus.imem_wr === 1'b1) begin
        if (bus.imem_waddr !== AW'(wr_count) ||
            bus.imem_wdata !== img_base + 32'(wr_count) * 32'd4)
          bad_wr++;
        wr_count++;
        last_wr_cyc = cyc;
      end
      if (bus.avm_rx_readdatavalid === 1'b1) last_valid_cyc = cyc;
      if (bus.avm_rx_read === 1'b1) n_reads++;
      if (prev_stalled && bus.avm_rx_read === 1'b1) begin
        check("stall_addr_stable", bus.avm_rx_address, prev_addr);
        check("stall_bc_stable", bus.avm_rx_burstcount, prev_bc);
      end
      prev_stalled = bus.avm_rx_read && bus.avm_rx_waitrequest;
      prev_addr    = bus.avm_rx_address;
      prev_bc      = bus.avm_rx_burstcount;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_load(input logic [31:0] src, input logic [AW:0] nw, input logic [31:0] base);
    wr_count = 0;
    bad_wr   = 0;
    n_reads  = 0;
    img_base = base;
    @(posedge clk);
    #1;
    src_addr  = src;
    num_words = nw;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget, output int dcyc);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, 64'(seen), 64'd1);
    dcyc = cyc;
  endtask

  task automatic push_bursts(input logic [31:0] base, input int n, input int len);
    for (int i = 0; i < n; i++)
      exp_q.push_back({12'(len), base + 32'(i) * 32'h400});
  endtask

  task automatic check_image(input string tag, input int n);
    check({tag, "_bad_writes"}, 64'(bad_wr), 64'd0);
    check({tag, "_write_count"}, 64'(wr_count), 64'(n));
    check({tag, "_bursts_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  int dc;
  int saved;
  bit hit;

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    src_addr  = '0;
    num_words = '0;
    bus.avm_rx_waitrequest   = 1'b0;
    bus.avm_rx_readdatavalid = 1'b0;
    bus.avm_rx_readdata      = '0;
    fork
      slave_proc();
      monitor_proc();
    join_none

    // Reset values
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_core_rstn", core_rstn, 0);
    check("rst_read", bus.avm_rx_read, 0);
    check("rst_imem_wr", bus.imem_wr, 0);
    check("rst_state", fsm_state, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic copy: one 16-beat burst, latency checks
    exp_q.push_back({12'd16, 32'h2000_0000});
    start_load(32'h2000_0000, 13'd16, 32'h2000_0000);
    check("basic_read_lat1", bus.avm_rx_read, 1);
    check("basic_addr", bus.avm_rx_address, 32'h2000_0000);
    check("basic_bc", bus.avm_rx_burstcount, 12'd16);
    check("basic_busy", busy, 1);
    wait_done("basic_done", 200, dc);
    check("basic_done_lat2", 64'(dc - last_valid_cyc), 64'd2);
    check("basic_wr_lat1", 64'(last_wr_cyc - last_valid_cyc), 64'd1);
    check("basic_rstn_held", core_rstn, 0);
    check("basic_busy_clr", busy, 0);
    @(negedge clk);
    check("basic_rstn_rise", core_rstn, 1);
    check_image("basic", 16);

    // Stray readdatavalid while idle must not write imem
    @(posedge clk);
    #1;
    junk_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    junk_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_valid_ignored", 64'(wr_count), 64'd16);

    // Multi-burst 600 words, with an ignored start during DATA
    exp_q.push_back({12'd256, 32'h3000_0000});
    exp_q.push_back({12'd256, 32'h3000_0400});
    exp_q.push_back({12'd88,  32'h3000_0800});
    start_load(32'h3000_0000, 13'd600, 32'h3000_0000);
    check("multi_done_cleared", done, 0);
    check("multi_rstn_cleared", core_rstn, 0);
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #2;
      if (fsm_state == 2'd2) begin
        hit = 1'b1;
        break;
      end
    end
    check("multi_reach_data", 64'(hit), 64'd1);
    src_addr  = 32'h5000_0000;
    num_words = 13'd5;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("multi_busy_after_start", busy, 1);
    wait_done("multi_done", 2000, dc);
    check_image("multi", 600);

    // Stalls and data gaps: 300 words -> 256 + 44
    stall_mode = 1'b1;
    gap_mode   = 1'b1;
    exp_q.push_back({12'd256, 32'h4000_0000});
    exp_q.push_back({12'd44,  32'h4000_0400});
    start_load(32'h4000_0000, 13'd300, 32'h4000_0000);
    wait_done("stall_done", 3000, dc);
    check_image("stall", 300);
    stall_mode = 1'b0;
    gap_mode   = 1'b0;

    // Zero words: straight to FIN, no read
    start_load(32'h2000_0000, 13'd0, 32'h0);
    check("zero_no_read", bus.avm_rx_read, 0);
    check("zero_state_fin", fsm_state, 3);
    wait_done("zero_done", 10, dc);
    check("zero_read_count", 64'(n_reads), 64'd0);
    check("zero_write_count", 64'(wr_count), 64'd0);

    // Clamp 5000 -> 4096 words, 16 bursts of 256
    push_bursts(32'h6000_0000, 16, 256);
    start_load(32'h6000_0000, 13'd5000, 32'h6000_0000);
    wait_done("clamp_done", 6000, dc);
    check_image("clamp", 4096);

    // Unaligned source address is issued word-aligned
    exp_q.push_back({12'd4, 32'h0000_1000});
    start_load(32'h0000_1003, 13'd4, 32'h0000_1000);
    check("unaligned_addr", bus.avm_rx_address, 32'h0000_1000);
    wait_done("unaligned_done", 100, dc);
    check_image("unaligned", 4);

    // Reset in the middle of DATA
    gap_mode = 1'b1;
    push_bursts(32'h7000_0000, 2, 256);
    exp_q.push_back({12'd88, 32'h7000_0800});
    start_load(32'h7000_0000, 13'd600, 32'h7000_0000);
    hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #2;
      if (bus.imem_wr === 1'b1 && wr_count >= 20) begin
        hit = 1'b1;
        break;
      end
    end
    check("midrst_reach_write", 64'(hit), 64'd1);
    reset = 1'b1;
    #1;
    check("midrst_imem_wr", bus.imem_wr, 0);
    check("midrst_read", bus.avm_rx_read, 0);
    check("midrst_core_rstn", core_rstn, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    saved = wr_count;
    repeat (4) @(negedge clk);
    check("midrst_no_writes", 64'(wr_count), 64'(saved));
    @(posedge clk);
    #1;
    reset = 1'b0;
    gap_mode = 1'b0;
    exp_q.delete();

    // Fresh load after reset completes normally
    exp_q.push_back({12'd16, 32'h2000_0100});
    start_load(32'h2000_0100, 13'd16, 32'h2000_0100);
    wait_done("after_rst_done", 200, dc);
    @(negedge clk);
    check("after_rst_rstn", core_rstn, 1);
    check_image("after_rst", 16);

`ifdef LOADER_TIMEOUT_EN
    // Watchdog: slave delivers 3 of 8 beats, then goes silent
    beat_budget = 3;
    exp_q.push_back({12'd8, 32'h8000_0000});
    start_load(32'h8000_0000, 13'd8, 32'h8000_0000);
    wait_done("timeout_done", 400, dc);
    check("timeout_lat", 64'(dc - last_valid_cyc), 64'd66);
    check("timeout_error", error, 1);
    beat_budget = -1;
    repeat (6) @(negedge clk);
    check("timeout_rstn_held", core_rstn, 0);
    check_image("timeout", 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not finish, observed %0d checks", n_total);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/imem_burst_loader.md
Name: imem_burst_loader

Overview:
- Avalon-MM burst-read master that copies a RISC-V program image from SDRAM into the core's instruction memory.
- It then releases the softcore from reset.
- Sits upstream of the imem write port and drives the currently unused avm_rx master interface.
- Replaces word-by-word CSR loading of imem. The CSR block supplies start, source address and word count.

Parameters:
- ADDR_WIDTH, 12, imem word-address width; capacity 2^ADDR_WIDTH words.
- MAX_BURST, 256, maximum beats per burst (1..2047).
- TIMEOUT_CYCLES, 1024, idle-beat watchdog limit (used only with LOADER_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- start  in  1  single-cycle load request.
- src_addr  in  32  SDRAM byte address of image; bits [1:0] ignored (treated as 0).
- num_words  in  ADDR_WIDTH+1  words to copy.
- busy  out  1  load in progress.
- done  out  1  sticky completion flag; cleared by next accepted start.
- error  out  1  sticky abort flag; cleared by next accepted start.
- core_rstn  out  1  active-low reset to rv32i core.
- avm_rx_waitrequest  in  1  Avalon slave stall.
- avm_rx_burstcount  out  12  beats in current burst.
- avm_rx_address  out  32  burst start byte address.
- avm_rx_read  out  1  burst read request.
- avm_rx_readdata  in  32  read data.
- avm_rx_readdatavalid  in  1  read data beat valid.
- imem_wr  out  1  imem write strobe.
- imem_waddr  out  ADDR_WIDTH  imem word address.
- imem_wdata  out  32  imem write data.

Behaviour:
- Reset values: every output 0. This includes core_rstn=0 (core held in reset), avm_rx_read=0, imem_wr=0, busy=0, done=0, error=0.
- Reset asserting mid-load clears all state asynchronously. avm_rx_read and imem_wr drop in the same instant. No further imem writes occur.
- Internal state: FSM IDLE, REQ, DATA, FIN.
- Internal registers: rd_addr (32), remaining (ADDR_WIDTH+1), wr_ptr (ADDR_WIDTH), beats_left (12).
- IDLE:
  - On start, latch rd_addr={src_addr[31:2],2'b00}.
  - Latch remaining=min(num_words, 2^ADDR_WIDTH).
  - Set wr_ptr=0, busy=1, done=0, error=0, core_rstn=0.
  - Go to REQ, or to FIN if the clamped count is 0.
- start is ignored whenever busy=1.
- REQ:
  - Drive avm_rx_read=1, avm_rx_address=rd_addr, avm_rx_burstcount=min(remaining, MAX_BURST).
  - Hold all three stable while avm_rx_waitrequest=1.
  - On the cycle read=1 and waitrequest=0: the command is accepted.
    - read deasserts next cycle.
    - beats_left=burstcount; remaining-=burstcount; rd_addr+=4*burstcount (mod 2^32).
    - Go to DATA.
- DATA:
  - Each cycle with avm_rx_readdatavalid=1: imem_wr=1 registered one cycle later.
  - The write carries imem_waddr=wr_ptr and imem_wdata=readdata captured on the valid beat.
  - wr_ptr increments by 1, wrapping at 2^ADDR_WIDTH. beats_left decrements.
  - readdatavalid on consecutive cycles yields back-to-back writes; no beats are dropped.
  - readdatavalid outside DATA is ignored.
  - When the final beat is received, go to REQ if remaining>0, else FIN.
  - Only one burst is outstanding at a time.
- FIN (one cycle):
  - busy=0, done=1.
  - core_rstn=1 from the following cycle (after the last imem write has issued).
  - Return to IDLE.
- core_rstn stays 1 until the next accepted start, which drives it 0 the cycle after start.
- Latency: start to first avm_rx_read is 1 cycle. Last readdatavalid to imem_wr is 1 cycle. Last readdatavalid to done=1 is 2 cycles.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on every readdatavalid and on entry to DATA. It increments each DATA cycle without a beat.
  - On reaching TIMEOUT_CYCLES: go to FIN with error=1 and done=1. core_rstn stays 0. Late beats for the aborted burst are ignored.
- Not defined: no counter is built and error is tied to 0.

Test Plan:
- Basic copy: src_addr=0x2000_0000, num_words=16, slave with 0 waitrequest returning data=address. Expect one burst with burstcount=16 and address 0x2000_0000; imem words 0..15 written with 0x2000_0000+4*i; done=1; core_rstn rises 1 cycle after done.
- Multi-burst: num_words=600, MAX_BURST=256. Expect bursts of 256, 256, 88 at addresses base, base+0x400, base+0x800. wr_ptr ends at 600 and exactly 600 imem writes occur.
- Stall and gaps: random waitrequest (3–5 cycles) and readdatavalid gaps. Expect address and burstcount stable while stalled; imem contents identical to no-stall run.
- Boundaries:
  - num_words=0: done next cycle, no avm_rx_read.
  - num_words=5000 (ADDR_WIDTH=12): clamped to 4096 words.
  - src_addr=0x1003: issued as 0x1000.
- Mid-op reset and start-while-busy: start pulsed during DATA is ignored. reset asserted during DATA gives avm_rx_read=0, imem_wr=0, core_rstn=0 immediately. A new start afterwards completes normally.
- Timeout (LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=64): slave stops after 3 of 8 beats. Expect error=1 and done=1 at 64 idle cycles, core_rstn held 0.
